hazard_bypass_controller: RTL and testbench

Pipeline controller that drives the hazard, flush and bypass control signals consumed by the fetch, decode and execute stages. Keeps a shadow copy of the destination-register state of the instructions in EX, MEM and WB. From that state and the decode-stage source registers it computes per-operand bypass selects, load-use stalls and branch-miss flush windows. Sits beside the 5-stage pipeline and drives the controller-side signals of the shared control interface.

---
 rtl/hazard_bypass_controller.sv | 170 +++++++++++++++++
 tb/tb_hazard_bypass_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_bypass_controller.sv
// Hazard/bypass controller: shadows the EX/MEM/WB destination state and drives bypass selects, load-use stalls and branch-miss flushes.
// Latency: all outputs are combinational from current inputs and shadow state; shadow state advances one stage per unfrozen clock.
// Backpressure: memBusy=1 freezes shadow state and the flush counter; outputs stay valid, misses are not accepted while frozen.
//
// Parameters: FLUSH_CYCLES (1..7) cycles isBranchPredictMiss stays high per miss; REG_ADDR_W register index width.
// Inputs : clk, rst (sync, active-high), decode fields (idValid, idRs1/2, idUsesRs1/2, idRd, idRegWrite, idIsLoad),
//          exBranchResolved/exBranchMiss from execute, memBusy from data memory.
// Outputs: isDataHazard (load-use stall), isBranchPredictMiss (flush), op1BypassCtrl/op2BypassCtrl
//          (0 regfile, 1 EX, 2 MEM, 3 WB).
// Optional: define HAZARD_PERF_CNT_EN to add stallCount/missCount performance counters.
module hazard_bypass_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  idUsesRs1,
  input  logic                  idUsesRs2,
  input  logic [REG_ADDR_W-1:0] idRd,
  input  logic                  idRegWrite,
  input  logic                  idIsLoad,
  input  logic                  exBranchResolved,
  input  logic                  exBranchMiss,
  input  logic                  memBusy,
  output logic                  isDataHazard,
  output logic                  isBranchPredictMiss,
  output logic [1:0]            op1BypassCtrl,
  output logic [1:0]            op2BypassCtrl
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stallCount,
  output logic [31:0]           missCount
`endif
);

  localparam logic [1:0] BYP_NONE = 2'd0;
  localparam logic [1:0] BYP_EX   = 2'd1;
  localparam logic [1:0] BYP_MEM  = 2'd2;
  localparam logic [1:0] BYP_WB   = 2'd3;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state, stateNext;
  logic [2:0] cnt, cntNext;
  logic       flushReq;
  logic       missAccept;

  // Shadow copy of the destination state of the instructions downstream of decode.
  logic                  exValid, exRegWrite, exIsLoad;
  logic [REG_ADDR_W-1:0] exRd;
  logic                  memValid, memRegWrite;
  logic [REG_ADDR_W-1:0] memRd;
  logic                  wbValid, wbRegWrite;
  logic [REG_ADDR_W-1:0] wbRd;

  // Operand qualifiers: x0 is never forwarded, even if a stage recorded rd=0 with regWrite.
  logic use1, use2;
  logic ex1Hit, ex2Hit, mem1Hit, mem2Hit, wb1Hit, wb2Hit;

  assign use1 = !rst && idValid && idUsesRs1 && (idRs1 != '0);
  assign use2 = !rst && idValid && idUsesRs2 && (idRs2 != '0);

  assign ex1Hit  = use1 && exValid  && exRegWrite  && (exRd  == idRs1);
  assign ex2Hit  = use2 && exValid  && exRegWrite  && (exRd  == idRs2);
  assign mem1Hit = use1 && memValid && memRegWrite && (memRd == idRs1);
  assign mem2Hit = use2 && memValid && memRegWrite && (memRd == idRs2);
  assign wb1Hit  = use1 && wbValid  && wbRegWrite  && (wbRd  == idRs1);
  assign wb2Hit  = use2 && wbValid  && wbRegWrite  && (wbRd  == idRs2);

  // Youngest producer wins.
  always_comb begin
    op1BypassCtrl = BYP_NONE;
    if (ex1Hit)       op1BypassCtrl = BYP_EX;
    else if (mem1Hit) op1BypassCtrl = BYP_MEM;
    else if (wb1Hit)  op1BypassCtrl = BYP_WB;
  end

  always_comb begin
    op2BypassCtrl = BYP_NONE;
    if (ex2Hit)       op2BypassCtrl = BYP_EX;
    else if (mem2Hit) op2BypassCtrl = BYP_MEM;
    else if (wb2Hit)  op2BypassCtrl = BYP_WB;
  end

  // Flush FSM: a miss is flagged in the same cycle it is seen; cnt counts the remaining extra cycles.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    flushReq   = 1'b0;
    missAccept = 1'b0;
    case (state)
      RUN: begin
        if (exBranchResolved && exBranchMiss && !memBusy) begin
          flushReq   = 1'b1;
          missAccept = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            stateNext = FLUSH;
            cntNext   = 3'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        flushReq = 1'b1;
        if (!memBusy) begin
          cntNext = cnt - 3'd1;
          if (cnt == 3'd1) stateNext = RUN;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  assign isBranchPredictMiss = flushReq && !rst;

  // A miss squashes the stall: the dependent instruction is flushed anyway.
  assign isDataHazard = exIsLoad && (ex1Hit || ex2Hit) && !isBranchPredictMiss;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exValid     <= 1'b0;
      exRegWrite  <= 1'b0;
      exIsLoad    <= 1'b0;
      exRd        <= '0;
      memValid    <= 1'b0;
      memRegWrite <= 1'b0;
      memRd       <= '0;
      wbValid     <= 1'b0;
      wbRegWrite  <= 1'b0;
      wbRd        <= '0;
    end else if (!memBusy) begin
      wbValid     <= memValid;
      wbRegWrite  <= memRegWrite;
      wbRd        <= memRd;
      memValid    <= exValid;
      memRegWrite <= exRegWrite;
      memRd       <= exRd;
      // A stalled or flushed decode slot enters EX as a bubble.
      exValid     <= idValid && !isDataHazard && !isBranchPredictMiss;
      exRegWrite  <= idRegWrite;
      exIsLoad    <= idIsLoad;
      exRd        <= idRd;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount <= 32'd0;
      missCount  <= 32'd0;
    end else begin
      if (isDataHazard || memBusy) stallCount <= stallCount + 32'd1;
      if (missAccept)              missCount  <= missCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_bypass_controller.sv
// Directed bench for hazard_bypass_controller: two instances (FLUSH_CYCLES=3 and 1) share all inputs.
// Each scenario task drives decode/branch/memBusy vectors and compares outputs against hand-derived values.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_hazard_bypass_controller;

  logic       clk;
  logic       rst;
  logic       idValid;
  logic [4:0] idRs1, idRs2, idRd;
  logic       idUsesRs1, idUsesRs2, idRegWrite, idIsLoad;
  logic       exBranchResolved, exBranchMiss, memBusy;

  logic       hz3, miss3, hz1, miss1;
  logic [1:0] op1s3, op2s3, op1s1, op2s1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall3, missC3, stall1, missC1;
  logic [31:0] s0;
`endif

  int passed = 0;
  int total  = 0;

  hazard_bypass_controller #(.FLUSH_CYCLES(3), .REG_ADDR_W(5)) dut3 (
    .clk(clk), .rst(rst), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .idRd(idRd), .idRegWrite(idRegWrite),
    .idIsLoad(idIsLoad), .exBranchResolved(exBranchResolved), .exBranchMiss(exBranchMiss),
    .memBusy(memBusy), .isDataHazard(hz3), .isBranchPredictMiss(miss3),
    .op1BypassCtrl(op1s3), .op2BypassCtrl(op2s3)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCount(stall3), .missCount(missC3)
`endif
  );

  hazard_bypass_controller #(.FLUSH_CYCLES(1), .REG_ADDR_W(5)) dut1 (
    .clk(clk), .rst(rst), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .idRd(idRd), .idRegWrite(idRegWrite),
    .idIsLoad(idIsLoad), .exBranchResolved(exBranchResolved), .exBranchMiss(exBranchMiss),
    .memBusy(memBusy), .isDataHazard(hz1), .isBranchPredictMiss(miss1),
    .op1BypassCtrl(op1s1), .op2BypassCtrl(op2s1)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCount(stall1), .missCount(missC1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setId(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic ld);
    idValid = v; idRs1 = r1; idRs2 = r2; idUsesRs1 = u1; idUsesRs2 = u2;
    idRd = rd; idRegWrite = rw; idIsLoad = ld;
  endtask

  task automatic idle();
    setId(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    exBranchResolved = 1'b0; exBranchMiss = 1'b0; memBusy = 1'b0;
  endtask

  task automatic randomInputs();
    setId(1'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom),
          1'($urandom), 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
    exBranchResolved = 1'($urandom); exBranchMiss = 1'($urandom); memBusy = 1'($urandom);
  endtask

  task automatic clearPipe();
    idle(); tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    randomInputs();
    tick();
    randomInputs();
    exBranchResolved = 1'b1; exBranchMiss = 1'b1;
    #1;
    total++; if (hz3 !== 1'b0)    $display("FAIL rst_hz3 got=%0d exp=0", hz3);       else passed++;
    total++; if (miss3 !== 1'b0)  $display("FAIL rst_miss3 got=%0d exp=0", miss3);   else passed++;
    total++; if (op1s3 !== 2'd0)  $display("FAIL rst_op1s3 got=%0d exp=0", op1s3);   else passed++;
    total++; if (op2s3 !== 2'd0)  $display("FAIL rst_op2s3 got=%0d exp=0", op2s3);   else passed++;
    total++; if (hz1 !== 1'b0)    $display("FAIL rst_hz1 got=%0d exp=0", hz1);       else passed++;
    total++; if (miss1 !== 1'b0)  $display("FAIL rst_miss1 got=%0d exp=0", miss1);   else passed++;
    total++; if (op1s1 !== 2'd0)  $display("FAIL rst_op1s1 got=%0d exp=0", op1s1);   else passed++;
    total++; if (op2s1 !== 2'd0)  $display("FAIL rst_op2s1 got=%0d exp=0", op2s1);   else passed++;
    tick();
    rst = 1'b0;
    idle();
    setId(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    total++; if (op1s3 !== 2'd0) $display("FAIL post_rst_op1 got=%0d exp=0", op1s3); else passed++;
    total++; if (hz3 !== 1'b0)   $display("FAIL post_rst_hz got=%0d exp=0", hz3);    else passed++;
`ifdef HAZARD_PERF_CNT_EN
    total++; if (stall3 !== 32'd0) $display("FAIL post_rst_stall got=%0d exp=0", stall3); else passed++;
`endif
  endtask

  task automatic test_forwarding();
    clearPipe();
    setId(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0); // add x5
    tick();
    setId(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); // add x6,x5,x5
    #1;
    total++; if (op1s3 !== 2'd1) $display("FAIL fwd_ex_op1 got=%0d exp=1", op1s3); else passed++;
    total++; if (op2s3 !== 2'd1) $display("FAIL fwd_ex_op2 got=%0d exp=1", op2s3); else passed++;
    total++; if (hz3 !== 1'b0)   $display("FAIL fwd_ex_hz got=%0d exp=0", hz3);     else passed++;
    idle(); tick();
    setId(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    total++; if (op1s3 !== 2'd2) $display("FAIL fwd_mem_op1 got=%0d exp=2", op1s3); else passed++;
    total++; if (op2s3 !== 2'd2) $display("FAIL fwd_mem_op2 got=%0d exp=2", op2s3); else passed++;
    idle(); tick();
    setId(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    total++; if (op1s3 !== 2'd3) $display("FAIL fwd_wb_op1 got=%0d exp=3", op1s3); else passed++;
    total++; if (op2s3 !== 2'd3) $display("FAIL fwd_wb_op2 got=%0d exp=3", op2s3); else passed++;
    // x5 written twice back to back: EX and MEM both hold x5.
    setId(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick(); tick();
    setId(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    total++; if (op1s3 !== 2'd1) $display("FAIL fwd_prio_op1 got=%0d exp=1", op1s3); else passed++;
    setId(1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    total++; if (op2s3 !== 2'd0) $display("FAIL fwd_unused_op2 got=%0d exp=0", op2s3); else passed++;
    setId(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    total++; if (op1s3 !== 2'd0) $display("FAIL fwd_novalid_op1 got=%0d exp=0", op1s3); else passed++;
    setId(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); // writes x0
    tick();
    setId(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    total++; if (op1s3 !== 2'd0) $display("FAIL fwd_x0_op1 got=%0d exp=0", op1s3); else passed++;
    total++; if (op2s3 !== 2'd0) $display("FAIL fwd_x0_op2 got=%0d exp=0", op2s3); else passed++;
  endtask

  task automatic test_load_use();
    clearPipe();
    setId(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1); // lw x7
    tick();
    setId(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    total++; if (hz3 !== 1'b1)   $display("FAIL lu_hz_on got=%0d exp=1", hz3);      else passed++;
    total++; if (op1s3 !== 2'd1) $display("FAIL lu_op1_ex got=%0d exp=1", op1s3);   else passed++;
    tick(); // decode holds the stalled instruction
    #1;
    total++; if (hz3 !== 1'b0)   $display("FAIL lu_hz_off got=%0d exp=0", hz3);     else passed++;
    total++; if (op1s3 !== 2'd2) $display("FAIL lu_op1_mem got=%0d exp=2", op1s3);  else passed++;
    total++; if (op2s3 !== 2'd0) $display("FAIL lu_bubble got=%0d exp=0", op2s3);   else passed++;
  endtask

  task automatic test_branch_miss();
    clearPipe();
    setId(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    exBranchResolved = 1'b1; exBranchMiss = 1'b1; // cycle t
    #1;
    total++; if (miss3 !== 1'b1) $display("FAIL br_t_miss3 got=%0d exp=1", miss3); else passed++;
    total++; if (miss1 !== 1'b1) $display("FAIL br_t_miss1 got=%0d exp=1", miss1); else passed++;
    tick(); // t+1: second miss presented
    setId(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    #1;
    total++; if (miss3 !== 1'b1) $display("FAIL br_t1_miss3 got=%0d exp=1", miss3); else passed++;
    total++; if (miss1 !== 1'b1) $display("FAIL br_t1_miss1 got=%0d exp=1", miss1); else passed++;
    total++; if (op1s3 !== 2'd0) $display("FAIL br_squash got=%0d exp=0", op1s3);   else passed++;
    tick(); // t+2
    exBranchResolved = 1'b0; exBranchMiss = 1'b0;
    #1;
    total++; if (miss3 !== 1'b1) $display("FAIL br_t2_miss3 got=%0d exp=1", miss3); else passed++;
    total++; if (miss1 !== 1'b0) $display("FAIL br_t2_miss1 got=%0d exp=0", miss1); else passed++;
    tick(); // t+3
    #1;
    total++; if (miss3 !== 1'b0) $display("FAIL br_t3_miss3 got=%0d exp=0", miss3); else passed++;
  endtask

  task automatic test_mem_busy();
    clearPipe();
    setId(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick(); // EX = x5
    setId(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    memBusy = 1'b1;
    #1;
`ifdef HAZARD_PERF_CNT_EN
    s0 = stall3;
`endif
    for (int i = 0; i < 4; i++) begin
      if (i >= 1) begin exBranchResolved = 1'b1; exBranchMiss = 1'b1; end
      #1;
      total++; if (op1s3 !== 2'd1) $display("FAIL busy_op1_c%0d got=%0d exp=1", i, op1s3); else passed++;
      total++; if (miss3 !== 1'b0) $display("FAIL busy_miss_c%0d got=%0d exp=0", i, miss3); else passed++;
      tick();
    end
    memBusy = 1'b0;
    #1;
    total++; if (miss3 !== 1'b1) $display("FAIL busy_miss_after got=%0d exp=1", miss3); else passed++;
    total++; if (op1s3 !== 2'd1) $display("FAIL busy_held_op1 got=%0d exp=1", op1s3);  else passed++;
`ifdef HAZARD_PERF_CNT_EN
    total++; if (stall3 - s0 !== 32'd4) $display("FAIL busy_stall_delta got=%0d exp=4", stall3 - s0); else passed++;
`endif
    idle();
    tick(); tick(); tick();
  endtask

  task automatic test_miss_loaduse_rst();
    clearPipe();
    setId(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1); // lw x7
    tick();
    setId(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    exBranchResolved = 1'b1; exBranchMiss = 1'b1;
    #1;
    total++; if (hz3 !== 1'b0)   $display("FAIL mlu_hz got=%0d exp=0", hz3);     else passed++;
    total++; if (miss3 !== 1'b1) $display("FAIL mlu_miss got=%0d exp=1", miss3); else passed++;
    tick();
    exBranchResolved = 1'b0; exBranchMiss = 1'b0;
    #1;
    total++; if (miss3 !== 1'b1) $display("FAIL mlu_flush got=%0d exp=1", miss3);   else passed++;
    total++; if (op1s3 !== 2'd2) $display("FAIL mlu_op1_mem got=%0d exp=2", op1s3); else passed++;
    rst = 1'b1; // mid-FLUSH
    tick();
    rst = 1'b0;
    #1;
    total++; if (miss3 !== 1'b0) $display("FAIL rstfl_miss got=%0d exp=0", miss3); else passed++;
    total++; if (hz3 !== 1'b0)   $display("FAIL rstfl_hz got=%0d exp=0", hz3);     else passed++;
    total++; if (op1s3 !== 2'd0) $display("FAIL rstfl_op1 got=%0d exp=0", op1s3);  else passed++;
`ifdef HAZARD_PERF_CNT_EN
    total++; if (missC3 !== 32'd0) $display("FAIL rstfl_misscnt got=%0d exp=0", missC3); else passed++;
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_miss();
    test_mem_busy();
    test_miss_loaduse_rst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
